// File: rtl/alu_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and execute.
// The slave modport is the decode stage's view; master is the fetch/execute side.
interface alu_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_operation;
  logic        alu_immediate_enable;
  logic [31:0] immediate_data;
  logic [4:0]  alu_shamt;
  logic        alu_shamt_from_reg;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        rd_write_enable;
  logic        illegal_instr;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, alu_operation, alu_immediate_enable, immediate_data,
           alu_shamt, alu_shamt_from_reg, rs1_addr, rs2_addr, rd_addr,
           rd_write_enable, illegal_instr
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, alu_operation, alu_immediate_enable, immediate_data,
           alu_shamt, alu_shamt_from_reg, rs1_addr, rs2_addr, rd_addr,
           rd_write_enable, illegal_instr
  );
endinterface

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage for OP, OP-IMM and LUI feeding the ALU.
// Optional macro DECODE_STRICT_FUNCT7_EN enables full funct7 legality checking.
module alu_decode_stage #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  alu_decode_stage_if.slave      bus,
  output logic [COUNT_WIDTH-1:0] decode_count_o
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_SLT  = 4'b0011,
    OP_SLTU = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SRA  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_OR   = 4'b1000,
    OP_AND  = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [31:0] instr;
  logic [2:0]  funct3;
  logic        altBit;

  alu_op_e     op_d,      op_q;
  logic        immEn_d,   immEn_q;
  logic [31:0] imm_d,     imm_q;
  logic        shReg_d,   shReg_q;
  logic [4:0]  rs1_d,     rs1_q;
  logic [4:0]  rs2_q;
  logic [4:0]  rd_q;
  logic [4:0]  shamt_q;
  logic        we_d,      we_q;
  logic        legal_d,   illegal_q;
  logic        valid_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic accept;
  logic outFire;

  assign instr   = bus.in_instr;
  assign funct3  = instr[14:12];
  assign altBit  = instr[30];

  assign bus.in_ready = ~valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign outFire      = valid_q & bus.out_ready;

  // Combinational decode of the offered word; illegal words collapse to a neutral add.
  always_comb begin
    op_d    = OP_ADD;
    immEn_d = 1'b0;
    imm_d   = 32'd0;
    shReg_d = 1'b0;
    legal_d = 1'b0;
    rs1_d   = instr[19:15];
    unique case (instr[6:0])
      OPC_OP_IMM: begin
        legal_d = 1'b1;
        immEn_d = 1'b1;
        imm_d   = {{20{instr[31]}}, instr[31:20]};
        unique case (funct3)
          3'b000: op_d = OP_ADD;
          3'b010: op_d = OP_SLT;
          3'b011: op_d = OP_SLTU;
          3'b100: op_d = OP_XOR;
          3'b110: op_d = OP_OR;
          3'b111: op_d = OP_AND;
          3'b001: begin
            op_d = OP_SLL;
`ifdef DECODE_STRICT_FUNCT7_EN
            legal_d = (instr[31:25] == 7'b0000000);
`endif
          end
          default: begin
            op_d = altBit ? OP_SRA : OP_SRL;
`ifdef DECODE_STRICT_FUNCT7_EN
            legal_d = (instr[31:25] == {1'b0, altBit, 5'b00000});
`endif
          end
        endcase
      end
      OPC_OP: begin
        legal_d = 1'b1;
        unique case (funct3)
          3'b000: op_d = altBit ? OP_SUB : OP_ADD;
          3'b001: begin op_d = OP_SLL; shReg_d = 1'b1; end
          3'b010: op_d = OP_SLT;
          3'b011: op_d = OP_SLTU;
          3'b100: op_d = OP_XOR;
          3'b110: op_d = OP_OR;
          3'b111: op_d = OP_AND;
          default: begin op_d = altBit ? OP_SRA : OP_SRL; shReg_d = 1'b1; end
        endcase
`ifdef DECODE_STRICT_FUNCT7_EN
        if ((funct3 == 3'b000) || (funct3 == 3'b101))
          legal_d = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000);
        else
          legal_d = (instr[31:25] == 7'b0000000);
`endif
      end
      OPC_LUI: begin
        legal_d = 1'b1;
        immEn_d = 1'b1;
        imm_d   = {instr[31:12], 12'h000};
        rs1_d   = 5'd0;
      end
      default: legal_d = 1'b0;
    endcase
    if (!legal_d) begin
      op_d    = OP_ADD;
      immEn_d = 1'b0;
      imm_d   = 32'd0;
      shReg_d = 1'b0;
    end
    we_d = legal_d & (instr[11:7] != 5'd0);
  end

  // Flush wins over accept; the delivery count still advances on a flush-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      count_q   <= '0;
      op_q      <= OP_ADD;
      immEn_q   <= 1'b0;
      imm_q     <= 32'd0;
      shReg_q   <= 1'b0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
      shamt_q   <= 5'd0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (outFire)
        count_q <= count_q + COUNT_WIDTH'(1);
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q   <= 1'b1;
        op_q      <= op_d;
        immEn_q   <= immEn_d;
        imm_q     <= imm_d;
        shReg_q   <= shReg_d;
        rs1_q     <= rs1_d;
        rs2_q     <= instr[24:20];
        rd_q      <= instr[11:7];
        shamt_q   <= instr[24:20];
        we_q      <= we_d;
        illegal_q <= ~legal_d;
      end else if (outFire) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid            = valid_q;
  assign bus.alu_operation        = op_q;
  assign bus.alu_immediate_enable = immEn_q;
  assign bus.immediate_data       = imm_q;
  assign bus.alu_shamt            = shamt_q;
  assign bus.alu_shamt_from_reg   = shReg_q;
  assign bus.rs1_addr             = rs1_q;
  assign bus.rs2_addr             = rs2_q;
  assign bus.rd_addr              = rd_q;
  assign bus.rd_write_enable      = we_q;
  assign bus.illegal_instr        = illegal_q;
  assign decode_count_o           = count_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed-vector bench for alu_decode_stage: decode table plus stall, flush and reset sequences.
// Build with +define+DECODE_STRICT_FUNCT7_EN to exercise the strict funct7 expectations.
module tb_alu_decode_stage;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] decodeCount;

  alu_decode_stage_if bus();

  alu_decode_stage #(.COUNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .bus            (bus),
    .decode_count_o (decodeCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic        immEn;
    logic [31:0] imm;
    logic        chkImm;
    logic [4:0]  shamt;
    logic        shReg;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  int            vectors = 0;
  int            miscompares = 0;
  logic [CW-1:0] expCount;
  vec_t          vecs[$];

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] XOR  = 32'h0020C233;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic oready, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = oready;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkFields(input string tag, input vec_t v);
    checkOutput({tag, ".op"},    64'(bus.alu_operation),        64'(v.op));
    checkOutput({tag, ".immEn"}, 64'(bus.alu_immediate_enable), 64'(v.immEn));
    if (v.chkImm)
      checkOutput({tag, ".imm"}, 64'(bus.immediate_data),       64'(v.imm));
    checkOutput({tag, ".shamt"}, 64'(bus.alu_shamt),            64'(v.shamt));
    checkOutput({tag, ".shReg"}, 64'(bus.alu_shamt_from_reg),   64'(v.shReg));
    checkOutput({tag, ".rs1"},   64'(bus.rs1_addr),             64'(v.rs1));
    checkOutput({tag, ".rs2"},   64'(bus.rs2_addr),             64'(v.rs2));
    checkOutput({tag, ".rd"},    64'(bus.rd_addr),              64'(v.rd));
    checkOutput({tag, ".we"},    64'(bus.rd_write_enable),      64'(v.we));
    checkOutput({tag, ".ill"},   64'(bus.illegal_instr),        64'(v.ill));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".outValid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, ".inReady"},  64'(bus.in_ready),  64'd1);
    checkOutput({tag, ".count"},    64'(decodeCount),   64'd0);
    checkOutput({tag, ".fields"},
                {4'd0, bus.alu_operation, bus.alu_immediate_enable, bus.immediate_data,
                 bus.alu_shamt, bus.alu_shamt_from_reg, bus.rs1_addr, bus.rs2_addr,
                 bus.rd_addr, bus.rd_write_enable, bus.illegal_instr}, 64'd0);
  endtask

  initial begin
    // instr, op, immEn, imm, chkImm, shamt, shReg, rs1, rs2, rd, we, ill
    vecs.push_back('{32'h00500093, 4'h0, 1'b1, 32'd5,        1'b1, 5'd5,  1'b0, 5'd0, 5'd5,  5'd1, 1'b1, 1'b0});
    vecs.push_back('{32'h402081B3, 4'h1, 1'b0, 32'd0,        1'b0, 5'd2,  1'b0, 5'd1, 5'd2,  5'd3, 1'b1, 1'b0});
    vecs.push_back('{32'h40335293, 4'h6, 1'b1, 32'h00000403, 1'b1, 5'd3,  1'b0, 5'd6, 5'd3,  5'd5, 1'b1, 1'b0});
    vecs.push_back('{32'h123453B7, 4'h0, 1'b1, 32'h12345000, 1'b1, 5'd3,  1'b0, 5'd0, 5'd3,  5'd7, 1'b1, 1'b0});
    vecs.push_back('{32'h00000000, 4'h0, 1'b0, 32'd0,        1'b0, 5'd0,  1'b0, 5'd0, 5'd0,  5'd0, 1'b0, 1'b1});
`ifdef DECODE_STRICT_FUNCT7_EN
    vecs.push_back('{32'h02208133, 4'h0, 1'b0, 32'd0,        1'b0, 5'd2,  1'b0, 5'd1, 5'd2,  5'd2, 1'b0, 1'b1});
    vecs.push_back('{32'h02335293, 4'h0, 1'b0, 32'd0,        1'b0, 5'd3,  1'b0, 5'd6, 5'd3,  5'd5, 1'b0, 1'b1});
`else
    vecs.push_back('{32'h02208133, 4'h0, 1'b0, 32'd0,        1'b0, 5'd2,  1'b0, 5'd1, 5'd2,  5'd2, 1'b1, 1'b0});
    vecs.push_back('{32'h02335293, 4'h7, 1'b1, 32'h00000023, 1'b1, 5'd3,  1'b0, 5'd6, 5'd3,  5'd5, 1'b1, 1'b0});
`endif
    vecs.push_back('{32'h0020C233, 4'h5, 1'b0, 32'd0,        1'b0, 5'd2,  1'b0, 5'd1, 5'd2,  5'd4, 1'b1, 1'b0});
    vecs.push_back('{32'h00209233, 4'h2, 1'b0, 32'd0,        1'b0, 5'd2,  1'b1, 5'd1, 5'd2,  5'd4, 1'b1, 1'b0});
    vecs.push_back('{32'h4020D233, 4'h6, 1'b0, 32'd0,        1'b0, 5'd2,  1'b1, 5'd1, 5'd2,  5'd4, 1'b1, 1'b0});
    vecs.push_back('{32'hFFF0F013, 4'h9, 1'b1, 32'hFFFFFFFF, 1'b1, 5'd31, 1'b0, 5'd1, 5'd31, 5'd0, 1'b0, 1'b0});
    vecs.push_back('{32'h8000B413, 4'h4, 1'b1, 32'hFFFFF800, 1'b1, 5'd0,  1'b0, 5'd1, 5'd0,  5'd8, 1'b1, 1'b0});
    vecs.push_back('{32'h0020A4B3, 4'h3, 1'b0, 32'd0,        1'b0, 5'd2,  1'b0, 5'd1, 5'd2,  5'd9, 1'b1, 1'b0});
    vecs.push_back('{32'h0020E4B3, 4'h8, 1'b0, 32'd0,        1'b0, 5'd2,  1'b0, 5'd1, 5'd2,  5'd9, 1'b1, 1'b0});
    vecs.push_back('{32'h0020D4B3, 4'h7, 1'b0, 32'd0,        1'b0, 5'd2,  1'b1, 5'd1, 5'd2,  5'd9, 1'b1, 1'b0});
    vecs.push_back('{32'h00500090, 4'h0, 1'b0, 32'd0,        1'b0, 5'd5,  1'b0, 5'd0, 5'd5,  5'd1, 1'b0, 1'b1});
    vecs.push_back('{32'h00208463, 4'h0, 1'b0, 32'd0,        1'b0, 5'd2,  1'b0, 5'd1, 5'd2,  5'd8, 1'b0, 1'b1});

    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkResetState("reset");
    rst = 1'b0;
    expCount = '0;

    // Back-to-back stream with execute always ready: one new word every cycle, no bubbles.
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].instr, 1'b1, 1'b0);
      if (i > 0) expCount++;
      checkOutput($sformatf("vec%0d.outValid", i), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("vec%0d.count", i),    64'(decodeCount),   64'(expCount));
      checkFields($sformatf("vec%0d", i), vecs[i]);
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    expCount++;
    checkOutput("drain.outValid", 64'(bus.out_valid), 64'd0);
    checkOutput("drain.count",    64'(decodeCount),   64'(expCount));

    // Stall: held word must not change while another word is being offered.
    applyStimulus(1'b1, SUB, 1'b0, 1'b0);
    checkOutput("stall.outValid", 64'(bus.out_valid), 64'd1);
    checkOutput("stall.inReady",  64'(bus.in_ready),  64'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, XOR, 1'b0, 1'b0);
      checkOutput($sformatf("stall%0d.outValid", k), 64'(bus.out_valid),     64'd1);
      checkOutput($sformatf("stall%0d.inReady", k),  64'(bus.in_ready),      64'd0);
      checkOutput($sformatf("stall%0d.op", k),       64'(bus.alu_operation), 64'h1);
      checkOutput($sformatf("stall%0d.immEn", k),    64'(bus.alu_immediate_enable), 64'd0);
      checkOutput($sformatf("stall%0d.regs", k),
                  64'({bus.rs1_addr, bus.rs2_addr, bus.rd_addr}), 64'({5'd1, 5'd2, 5'd3}));
      checkOutput($sformatf("stall%0d.count", k),    64'(decodeCount),       64'(expCount));
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    expCount++;
    checkOutput("unstall.outValid", 64'(bus.out_valid), 64'd0);
    checkOutput("unstall.count",    64'(decodeCount),   64'(expCount));

    // Flush during a stall with a word offered: both are dropped, nothing counted.
    applyStimulus(1'b1, ADDI, 1'b0, 1'b0);
    checkOutput("preFlush.outValid", 64'(bus.out_valid), 64'd1);
    applyStimulus(1'b1, XOR, 1'b0, 1'b1);
    checkOutput("flush.outValid", 64'(bus.out_valid), 64'd0);
    checkOutput("flush.count",    64'(decodeCount),   64'(expCount));
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("postFlush.outValid", 64'(bus.out_valid), 64'd0);
    checkOutput("postFlush.count",    64'(decodeCount),   64'(expCount));

    // Flush coinciding with an output handshake still counts the delivered word.
    applyStimulus(1'b1, ADDI, 1'b0, 1'b0);
    applyStimulus(1'b1, XOR, 1'b1, 1'b1);
    expCount++;
    checkOutput("flushFire.outValid", 64'(bus.out_valid), 64'd0);
    checkOutput("flushFire.count",    64'(decodeCount),   64'(expCount));

    // Reset in the middle of a stall returns everything to reset values.
    applyStimulus(1'b1, XOR, 1'b0, 1'b0);
    applyStimulus(1'b1, SUB, 1'b0, 1'b0);
    checkOutput("midStall.outValid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    applyStimulus(1'b1, SUB, 1'b1, 1'b1);
    checkResetState("stallReset");
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
